// File: rtl/pipelined_data_memory.sv
// pipelined_data_memory: byte-lane data RAM for the multi-cycle / pipelined MIPS datapaths.
// Accepts one request at a time over req/ready. Completion is a one-cycle done pulse, qualified
// by fault for rejected requests. Optional split (two-beat) unaligned words are enabled by
// defining PIPELINED_DATA_MEMORY_UNALIGNED_EN; otherwise unaligned size-2 accesses fault.
//
// Ports:
//   clock, reset          sole clock; asynchronous active-high reset
//   req_in / ready_out    request strobe / block can accept a request
//   addr_in, data_in      byte address, write data
//   size_in               0 byte, 1 half, 2 unaligned word, 3 aligned word
//   we_in, re_in          write (wins) / read request
//   data_out              read result, valid while done_out is high
//   done_out, fault_out   completion pulse, request rejected
module pipelined_data_memory #(
    parameter logic [15:0] MEM_ADDR      = 16'h1000,
    parameter int unsigned NUM_WORDS     = 1024,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned DO_INIT       = 0,
    parameter string       INIT_PROGRAM0 = "test/data_ram0.memh",
    parameter string       INIT_PROGRAM1 = "test/data_ram1.memh",
    parameter string       INIT_PROGRAM2 = "test/data_ram2.memh",
    parameter string       INIT_PROGRAM3 = "test/data_ram3.memh"
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_in,
    output logic        ready_out,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    input  logic [1:0]  size_in,
    input  logic        we_in,
    input  logic        re_in,
    output logic [31:0] data_out,
    output logic        done_out,
    output logic        fault_out
);

    localparam int unsigned NUM_WORDS_LOG = $clog2(NUM_WORDS);
    localparam logic [2:0]  LAT_M1        = 3'(READ_LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBeat2, StWait, StDone} state_e;

    state_e                     state_q, state_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic [NUM_WORDS_LOG-1:0]   idx_q;
    logic                       rd_q, fault_q, first_q;
    logic [31:0]                data_q;

    logic                       accept, fault_in, split_in, rd_in;
    logic [1:0]                 off_in;
    logic [NUM_WORDS_LOG-1:0]   idx_in;
    logic [3:0]                 be_in;
    logic [31:0]                wdata_in;

    logic                       mem_we;
    logic [NUM_WORDS_LOG-1:0]   mem_idx;
    logic [3:0]                 mem_be;
    logic [31:0]                mem_wdata;
    logic [31:0]                rd_a;

    // Address bits between the word index and the region tag are don't-care.
    logic unused_addr;
    assign unused_addr = ^addr_in;

    assign ready_out = (state_q == StIdle) || (state_q == StDone);
    assign done_out  = (state_q == StDone);
    assign fault_out = done_out && fault_q;
    assign data_out  = data_q;

    assign accept = req_in && ready_out && !reset;
    assign off_in = addr_in[1:0];
    assign idx_in = addr_in[NUM_WORDS_LOG+1:2];
    assign rd_in  = re_in && !we_in && !fault_in;

    // Request decode: fault, split detection, lane enables and replicated write data.
    always_comb begin
        fault_in = 1'b0;
        split_in = 1'b0;
        if (we_in || re_in) begin
            if (addr_in[31:16] != MEM_ADDR)            fault_in = 1'b1;
            if (size_in == 2'd1 && addr_in[0])         fault_in = 1'b1;
            if (size_in == 2'd3 && off_in != 2'd0)     fault_in = 1'b1;
`ifdef PIPELINED_DATA_MEMORY_UNALIGNED_EN
            split_in = !fault_in && size_in == 2'd2 && off_in != 2'd0;
`else
            if (size_in == 2'd2 && off_in != 2'd0)     fault_in = 1'b1;
`endif
        end
        unique case (size_in)
            2'd0: begin
                be_in    = 4'b0001 << off_in;
                wdata_in = {4{data_in[7:0]}};
            end
            2'd1: begin
                be_in    = addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{data_in[15:0]}};
            end
            default: begin
                // Aligned words have off_in = 0; split beat 1 takes lanes off..3.
                be_in    = 4'b1111 << off_in;
                wdata_in = data_in << {off_in, 3'b000};
            end
        endcase
    end

`ifdef PIPELINED_DATA_MEMORY_UNALIGNED_EN
    logic [1:0]               off_q;
    logic [31:0]              wdata_q, lo_q;
    logic                     wr_q, split_q, second_q;
    logic [NUM_WORDS_LOG-1:0] idx_b;
    logic [31:0]              rd_b;
    logic [3:0]               be_b2;
    logic [63:0]              rd_cat;

    assign idx_b  = idx_q + 1'b1;  // wraps modulo NUM_WORDS
    assign be_b2  = ~(4'b1111 << off_q);
    assign rd_cat = {rd_b, lo_q} >> {off_q, 3'b000};
`endif

    // Single write port: request-time writes at the accepting edge, beat 2 one edge later.
    always_comb begin
        mem_we    = accept && we_in && !fault_in;
        mem_idx   = idx_in;
        mem_be    = be_in;
        mem_wdata = wdata_in;
`ifdef PIPELINED_DATA_MEMORY_UNALIGNED_EN
        if (state_q == StBeat2) begin
            mem_we    = wr_q;
            mem_idx   = idx_b;
            mem_be    = be_b2;
            mem_wdata = wdata_q >> {(3'd4 - {1'b0, off_q}), 3'b000};
        end
`endif
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [7:0] ram [NUM_WORDS];

        always_ff @(posedge clock) begin
            if (mem_we && mem_be[k]) ram[mem_idx] <= mem_wdata[8*k +: 8];
        end

        assign rd_a[8*k +: 8] = ram[idx_q];
`ifdef PIPELINED_DATA_MEMORY_UNALIGNED_EN
        assign rd_b[8*k +: 8] = ram[idx_b];
`endif
    end

    // The WAIT counter holds the number of extra cycles before DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    if (split_in) begin
                        state_d = StBeat2;
                    end else begin
                        state_d = StWait;
                        cnt_d   = rd_in ? LAT_M1 : 3'd0;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StBeat2: begin
                state_d = StWait;
                cnt_d   = rd_q ? LAT_M1 : 3'd0;
            end
            StWait: begin
                if (cnt_q == 3'd0) state_d = StDone;
                else               cnt_d   = cnt_q - 3'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            idx_q   <= '0;
            rd_q    <= 1'b0;
            fault_q <= 1'b0;
            first_q <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= accept;
            if (accept) begin
                idx_q   <= idx_in;
                rd_q    <= rd_in;
                fault_q <= fault_in;
            end
`ifdef PIPELINED_DATA_MEMORY_UNALIGNED_EN
            if (first_q && !split_q) data_q <= rd_q ? rd_a : 32'd0;
            if (second_q)            data_q <= rd_q ? rd_cat[31:0] : 32'd0;
`else
            if (first_q)             data_q <= rd_q ? rd_a : 32'd0;
`endif
        end
    end

`ifdef PIPELINED_DATA_MEMORY_UNALIGNED_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            off_q    <= 2'd0;
            wdata_q  <= 32'd0;
            lo_q     <= 32'd0;
            wr_q     <= 1'b0;
            split_q  <= 1'b0;
            second_q <= 1'b0;
        end else begin
            second_q <= (state_q == StBeat2);
            if (state_q == StBeat2) lo_q <= rd_a;
            if (accept) begin
                off_q   <= off_in;
                wdata_q <= data_in;
                wr_q    <= we_in && !fault_in;
                split_q <= split_in;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_data_memory.sv
// Directed bench for pipelined_data_memory with READ_LATENCY = 3 and NUM_WORDS = 1024.
// Unaligned-word expectations follow PIPELINED_DATA_MEMORY_UNALIGNED_EN when it is defined.
module tb_pipelined_data_memory;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_in = 1'b0;
    logic        ready_out;
    logic [31:0] addr_in = 32'd0;
    logic [31:0] data_in = 32'd0;
    logic [1:0]  size_in = 2'd0;
    logic        we_in = 1'b0;
    logic        re_in = 1'b0;
    logic [31:0] data_out;
    logic        done_out;
    logic        fault_out;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    pipelined_data_memory #(
        .MEM_ADDR     (16'h1000),
        .NUM_WORDS    (1024),
        .READ_LATENCY (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_in    (req_in),
        .ready_out (ready_out),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .size_in   (size_in),
        .we_in     (we_in),
        .re_in     (re_in),
        .data_out  (data_out),
        .done_out  (done_out),
        .fault_out (fault_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request (caller sits just after an edge with ready high) and wait for done.
    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic w, input logic r,
                      input int exp_lat, input logic [31:0] exp_data, input logic exp_flt);
        int lat;
        addr_in = a;
        data_in = d;
        size_in = sz;
        we_in   = w;
        re_in   = r;
        req_in  = 1'b1;
        @(posedge clock);
        #1;
        req_in = 1'b0;
        lat    = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!done_out && lat < 30);
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".data"}, data_out, exp_data);
        check({tag, ".fault"}, {31'd0, fault_out}, {31'd0, exp_flt});
    endtask

    logic [31:0] exp_w0;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst.ready", {31'd0, ready_out}, 32'd1);
        check("rst.done", {31'd0, done_out}, 32'd0);
        check("rst.fault", {31'd0, fault_out}, 32'd0);
        check("rst.data", data_out, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Aligned word round trip
        op("aw", 32'h1000_0010, 32'hDEAD_BEEF, 2'd3, 1'b1, 1'b0, 1, 32'd0, 1'b0);
        op("ar", 32'h1000_0010, 32'd0, 2'd3, 1'b0, 1'b1, 3, 32'hDEAD_BEEF, 1'b0);

        // Byte and half writes into a cleared word 0
        op("z0", 32'h1000_0000, 32'd0, 2'd3, 1'b1, 1'b0, 1, 32'd0, 1'b0);
        op("wb", 32'h1000_0002, 32'h0000_00AB, 2'd0, 1'b1, 1'b0, 1, 32'd0, 1'b0);
        op("wh", 32'h1000_0000, 32'h0000_1234, 2'd1, 1'b1, 1'b0, 1, 32'd0, 1'b0);
        op("rbh", 32'h1000_0000, 32'd0, 2'd3, 1'b0, 1'b1, 3, 32'h00AB_1234, 1'b0);
        op("rb0", 32'h1000_0001, 32'd0, 2'd0, 1'b0, 1'b1, 3, 32'h00AB_1234, 1'b0);

        // Size 2 at offset 0 behaves as an aligned word
        op("w2a", 32'h1000_0010, 32'hCAFE_F00D, 2'd2, 1'b1, 1'b0, 1, 32'd0, 1'b0);
        op("r2a", 32'h1000_0010, 32'd0, 2'd2, 1'b0, 1'b1, 3, 32'hCAFE_F00D, 1'b0);

        op("z4", 32'h1000_0004, 32'd0, 2'd3, 1'b1, 1'b0, 1, 32'd0, 1'b0);
        op("z8", 32'h1000_0008, 32'd0, 2'd3, 1'b1, 1'b0, 1, 32'd0, 1'b0);
`ifdef PIPELINED_DATA_MEMORY_UNALIGNED_EN
        op("wu", 32'h1000_0005, 32'h4433_2211, 2'd2, 1'b1, 1'b0, 2, 32'd0, 1'b0);
        op("ru0", 32'h1000_0004, 32'd0, 2'd3, 1'b0, 1'b1, 3, 32'h3322_1100, 1'b0);
        op("ru1", 32'h1000_0008, 32'd0, 2'd3, 1'b0, 1'b1, 3, 32'h0000_0044, 1'b0);
        op("ru", 32'h1000_0005, 32'd0, 2'd2, 1'b0, 1'b1, 4, 32'h4433_2211, 1'b0);
        // Beat 2 of an access at the last word wraps to word 0
        op("zl", 32'h1000_0FFC, 32'd0, 2'd3, 1'b1, 1'b0, 1, 32'd0, 1'b0);
        op("zf", 32'h1000_0000, 32'd0, 2'd3, 1'b1, 1'b0, 1, 32'd0, 1'b0);
        op("wwrap", 32'h1000_0FFE, 32'hA1B2_C3D4, 2'd2, 1'b1, 1'b0, 2, 32'd0, 1'b0);
        op("rwl", 32'h1000_0FFC, 32'd0, 2'd3, 1'b0, 1'b1, 3, 32'hC3D4_0000, 1'b0);
        op("rwf", 32'h1000_0000, 32'd0, 2'd3, 1'b0, 1'b1, 3, 32'h0000_A1B2, 1'b0);
        op("rwrap", 32'h1000_0FFE, 32'd0, 2'd2, 1'b0, 1'b1, 4, 32'hA1B2_C3D4, 1'b0);
        exp_w0 = 32'h0000_A1B2;
`else
        op("wu", 32'h1000_0005, 32'h4433_2211, 2'd2, 1'b1, 1'b0, 1, 32'd0, 1'b1);
        op("ru0", 32'h1000_0004, 32'd0, 2'd3, 1'b0, 1'b1, 3, 32'd0, 1'b0);
        op("ru1", 32'h1000_0008, 32'd0, 2'd3, 1'b0, 1'b1, 3, 32'd0, 1'b0);
        op("ru", 32'h1000_0005, 32'd0, 2'd2, 1'b0, 1'b1, 1, 32'd0, 1'b1);
        exp_w0 = 32'h00AB_1234;
`endif

        // Faults: out of region (aliases word 0), misaligned half and word; no memory change
        op("fr", 32'h2000_0000, 32'hFFFF_FFFF, 2'd3, 1'b1, 1'b0, 1, 32'd0, 1'b1);
        op("fh", 32'h1000_0001, 32'hFFFF_FFFF, 2'd1, 1'b1, 1'b0, 1, 32'd0, 1'b1);
        op("fw", 32'h1000_0002, 32'hFFFF_FFFF, 2'd3, 1'b1, 1'b0, 1, 32'd0, 1'b1);
        op("rw0", 32'h1000_0000, 32'd0, 2'd3, 1'b0, 1'b1, 3, exp_w0, 1'b0);
        op("frd", 32'h3000_0010, 32'd0, 2'd3, 1'b0, 1'b1, 1, 32'd0, 1'b1);

        // No-op and write-beats-read
        op("noop", 32'h1000_0010, 32'd0, 2'd3, 1'b0, 1'b0, 1, 32'd0, 1'b0);
        op("wre", 32'h1000_0010, 32'h0000_0055, 2'd3, 1'b1, 1'b1, 1, 32'd0, 1'b0);
        op("rwre", 32'h1000_0010, 32'd0, 2'd3, 1'b0, 1'b1, 3, 32'h0000_0055, 1'b0);
        op("w14", 32'h1000_0014, 32'h0BAD_F00D, 2'd3, 1'b1, 1'b0, 1, 32'd0, 1'b0);

        // Back-to-back reads with req_in held high
        b2b_addr[0] = 32'h1000_0010; b2b_data[0] = 32'h0000_0055;
        b2b_addr[1] = 32'h1000_0014; b2b_data[1] = 32'h0BAD_F00D;
        b2b_addr[2] = 32'h1000_0000; b2b_data[2] = exp_w0;
        addr_in = b2b_addr[0];
        size_in = 2'd3;
        we_in   = 1'b0;
        re_in   = 1'b1;
        req_in  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int lat;
            @(posedge clock);
            #1;
            check("b2b.busy", {31'd0, ready_out}, 32'd0);
            check("b2b.pulse", {31'd0, done_out}, 32'd0);
            lat = 0;
            do begin
                @(posedge clock);
                #1;
                lat++;
            end while (!done_out && lat < 30);
            check("b2b.lat", 32'(lat), 32'd3);
            check("b2b.data", data_out, b2b_data[i]);
            check("b2b.ready", {31'd0, ready_out}, 32'd1);
            if (i < 2) addr_in = b2b_addr[i+1];
            else       req_in = 1'b0;
        end

        // Asynchronous reset in the middle of an operation
`ifdef PIPELINED_DATA_MEMORY_UNALIGNED_EN
        op("z20", 32'h1000_0020, 32'd0, 2'd3, 1'b1, 1'b0, 1, 32'd0, 1'b0);
        op("z24", 32'h1000_0024, 32'd0, 2'd3, 1'b1, 1'b0, 1, 32'd0, 1'b0);
        addr_in = 32'h1000_0022;
        data_in = 32'h1122_3344;
        size_in = 2'd2;
        we_in   = 1'b1;
        re_in   = 1'b0;
`else
        addr_in = 32'h1000_0010;
        size_in = 2'd3;
        we_in   = 1'b0;
        re_in   = 1'b1;
`endif
        req_in = 1'b1;
        @(posedge clock);
        #1;
        req_in = 1'b0;
        check("mid.busy", {31'd0, ready_out}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("mid.ready", {31'd0, ready_out}, 32'd1);
        check("mid.done", {31'd0, done_out}, 32'd0);
        check("mid.fault", {31'd0, fault_out}, 32'd0);
        check("mid.data", data_out, 32'd0);
        repeat (3) begin
            @(posedge clock);
            #1;
            check("mid.nodone", {31'd0, done_out}, 32'd0);
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("mid.after", {31'd0, done_out}, 32'd0);
`ifdef PIPELINED_DATA_MEMORY_UNALIGNED_EN
        op("mid.b1", 32'h1000_0020, 32'd0, 2'd3, 1'b0, 1'b1, 3, 32'h3344_0000, 1'b0);
        op("mid.b2", 32'h1000_0024, 32'd0, 2'd3, 1'b0, 1'b1, 3, 32'd0, 1'b0);
`else
        op("mid.rd", 32'h1000_0010, 32'd0, 2'd3, 1'b0, 1'b1, 3, 32'h0000_0055, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
